// File: rtl/oled_pkg.sv
// Shared constants and types for the SSD1306 panel-side SPI receiver.
//   Command opcodes, panel geometry, frame-buffer depth and the command
//   decoder state type.
package oled_pkg;

  localparam logic [7:0] CMD_SET_COL  = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE = 8'h22;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;

  localparam int unsigned OLED_COLS  = 128;
  localparam int unsigned OLED_PAGES = 8;
  localparam int unsigned FB_DEPTH   = OLED_COLS * OLED_PAGES;

  // Command decoder: idle, or waiting for the first/second argument of a
  // column or page address command.
  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_COL_A  = 3'd1,
    ST_COL_B  = 3'd2,
    ST_PAGE_A = 3'd3,
    ST_PAGE_B = 3'd4
  } cmd_state_e;

endpackage

// File: rtl/oled_framebuffer.sv
// GDDRAM mirror: simple dual-port RAM, one write port and one registered
// read port. Same-address read/write returns the old contents.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address (page*COLS + column)
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, one clock after raddr_i
module oled_framebuffer
  import oled_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // No reset on the array or read register so the tools can map to block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// Panel-side emulation of the SSD1306 4-wire SPI interface.
// Deserialises SCLK/SDIN bytes under CS, decodes the column/page window and
// display on/off commands, and stores data bytes in a GDDRAM mirror.
//   clk, resetN          : system clock, async active-low reset
//   ioSclk/ioSdin/ioCs   : SPI clock (rising-edge sample), data (MSB first),
//                          chip select (active low), all asynchronous
//   ioDc                 : 0 = command byte, 1 = data byte
//   ioReset              : panel reset, active low, asynchronous
//   pixelAddress/Data    : mirror read port, data one clock after address
//   byteValid/Data/IsData: per-byte pulse, last byte, its D/C bit
//   displayOn            : display on/off state
//   frameDone            : pulse when the write pointer wraps the window
module ssd1306_spi_receiver
  import oled_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLS        = OLED_COLS,
  parameter int unsigned PAGES       = OLED_PAGES
) (
  input  logic                                   clk,
  input  logic                                   resetN,
  input  logic                                   ioSclk,
  input  logic                                   ioSdin,
  input  logic                                   ioCs,
  input  logic                                   ioDc,
  input  logic                                   ioReset,
  input  logic [$clog2(COLS)+$clog2(PAGES)-1:0]  pixelAddress,
  output logic [7:0]                             pixelData,
  output logic                                   byteValid,
  output logic [7:0]                             byteData,
  output logic                                   byteIsData,
  output logic                                   displayOn,
  output logic                                   frameDone
);

  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned PAGE_W = $clog2(PAGES);
  localparam int unsigned ADDR_W = COL_W + PAGE_W;
  localparam int unsigned IO_W   = 5;

  // Synchroniser bit positions: {ioReset, ioDc, ioCs, ioSdin, ioSclk}
  localparam logic [IO_W-1:0] SYNC_RST_VAL = 5'b10100;

  logic [SYNC_STAGES-1:0][IO_W-1:0] sync_q;
  logic                             sclk_prev_q;
  logic                             sclk_s, sdin_s, cs_s, dc_s, rst_s;
  logic                             sclk_rise_c, soft_rst_c, we_c;

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_is_data_q, byte_is_data_d;
  logic              display_on_q, display_on_d;
  logic              frame_done_q, frame_done_d;
  cmd_state_e        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PAGE_W-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;

  assign sclk_s = sync_q[SYNC_STAGES-1][0];
  assign sdin_s = sync_q[SYNC_STAGES-1][1];
  assign cs_s   = sync_q[SYNC_STAGES-1][2];
  assign dc_s   = sync_q[SYNC_STAGES-1][3];
  assign rst_s  = sync_q[SYNC_STAGES-1][4];

  assign sclk_rise_c = sclk_s & ~sclk_prev_q;
  assign soft_rst_c  = ~rst_s;

  // Input synchronisers and SCLK edge history.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_q      <= {SYNC_STAGES{SYNC_RST_VAL}};
      sclk_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], {ioReset, ioDc, ioCs, ioSdin, ioSclk}};
      sclk_prev_q <= sclk_s;
    end
  end

  // Deserialiser, write-pointer and command decoder next state.
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    display_on_d   = display_on_q;
    frame_done_d   = 1'b0;
    state_d        = state_q;
    col_d          = col_q;
    page_d         = page_q;
    col_start_d    = col_start_q;
    col_end_d      = col_end_q;
    page_start_d   = page_start_q;
    page_end_d     = page_end_q;

    if (soft_rst_c) begin
      // Panel reset wins over any byte completing in the same cycle.
      bit_cnt_d      = 3'd0;
      shift_d        = 7'd0;
      byte_data_d    = 8'd0;
      byte_is_data_d = 1'b0;
      display_on_d   = 1'b0;
      state_d        = ST_CMD;
      col_d          = '0;
      page_d         = '0;
      col_start_d    = '0;
      col_end_d      = COL_W'(COLS - 1);
      page_start_d   = '0;
      page_end_d     = PAGE_W'(PAGES - 1);
    end else begin
      if (cs_s) begin
        bit_cnt_d = 3'd0;
      end else if (sclk_rise_c) begin
        shift_d   = {shift_q[5:0], sdin_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_d   = 1'b1;
          byte_data_d    = {shift_q, sdin_s};
          byte_is_data_d = dc_s;
        end
      end

      // Act on the byte during its byteValid cycle.
      if (byte_valid_q) begin
        if (byte_is_data_q) begin
          state_d = ST_CMD;
          if (col_q == col_end_q) begin
            col_d = col_start_q;
            if (page_q == page_end_q) begin
              page_d       = page_start_q;
              frame_done_d = 1'b1;
            end else begin
              page_d = page_q + PAGE_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          case (state_q)
            ST_CMD: begin
              case (byte_data_q)
                CMD_SET_COL:  state_d = ST_COL_A;
                CMD_SET_PAGE: state_d = ST_PAGE_A;
                CMD_DISP_ON:  display_on_d = 1'b1;
                CMD_DISP_OFF: display_on_d = 1'b0;
                default:      state_d = ST_CMD;
              endcase
            end
            ST_COL_A: begin
              col_start_d = byte_data_q[COL_W-1:0];
              col_d       = byte_data_q[COL_W-1:0];
              state_d     = ST_COL_B;
            end
            ST_COL_B: begin
              col_end_d = byte_data_q[COL_W-1:0];
              state_d   = ST_CMD;
            end
            ST_PAGE_A: begin
              page_start_d = byte_data_q[PAGE_W-1:0];
              page_d       = byte_data_q[PAGE_W-1:0];
              state_d      = ST_PAGE_B;
            end
            ST_PAGE_B: begin
              page_end_d = byte_data_q[PAGE_W-1:0];
              state_d    = ST_CMD;
            end
            default: state_d = ST_CMD;
          endcase
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bit_cnt_q      <= 3'd0;
      shift_q        <= 7'd0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'd0;
      byte_is_data_q <= 1'b0;
      display_on_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      state_q        <= ST_CMD;
      col_q          <= '0;
      page_q         <= '0;
      col_start_q    <= '0;
      col_end_q      <= COL_W'(COLS - 1);
      page_start_q   <= '0;
      page_end_q     <= PAGE_W'(PAGES - 1);
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      display_on_q   <= display_on_d;
      frame_done_q   <= frame_done_d;
      state_q        <= state_d;
      col_q          <= col_d;
      page_q         <= page_d;
      col_start_q    <= col_start_d;
      col_end_q      <= col_end_d;
      page_start_q   <= page_start_d;
      page_end_q     <= page_end_d;
    end
  end

  assign we_c = byte_valid_q & byte_is_data_q & ~soft_rst_c;

  oled_framebuffer #(
    .DEPTH (COLS * PAGES),
    .AW    (ADDR_W)
  ) u_fb (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i ({page_q, col_q}),
    .wdata_i (byte_data_q),
    .raddr_i (pixelAddress),
    .rdata_o (pixelData)
  );

  assign byteValid  = byte_valid_q;
  assign byteData   = byte_data_q;
  assign byteIsData = byte_is_data_q;
  assign displayOn  = display_on_q;
  assign frameDone  = frame_done_q;

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Self-checking bench for ssd1306_spi_receiver: a directed vector table,
// hand-written corner sequences, then random traffic against a reference
// model of the panel's addressing rules.
module tb_ssd1306_spi_receiver;

  logic       clk = 1'b0;
  logic       resetN;
  logic       ioSclk, ioSdin, ioCs, ioDc, ioReset;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData;
  logic       byteValid;
  logic [7:0] byteData;
  logic       byteIsData;
  logic       displayOn;
  logic       frameDone;

  ssd1306_spi_receiver #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .ioSclk       (ioSclk),
    .ioSdin       (ioSdin),
    .ioCs         (ioCs),
    .ioDc         (ioDc),
    .ioReset      (ioReset),
    .pixelAddress (pixelAddress),
    .pixelData    (pixelData),
    .byteValid    (byteValid),
    .byteData     (byteData),
    .byteIsData   (byteIsData),
    .displayOn    (displayOn),
    .frameDone    (frameDone)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int vcount = 0;
  int fcount = 0;

  // Pulse counters observed away from the active edge.
  always @(negedge clk) begin
    if (byteValid) vcount++;
    if (frameDone) fcount++;
  end

  // Reference model: panel addressing from the command rules.
  logic [7:0] m_mem [1024];
  bit         m_known [1024];
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_arg, m_frames;
  bit m_disp;

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_arg = 0; m_disp = 1'b0;
  endtask

  // m_arg: 0 none, 1 col start, 2 col end, 3 page start, 4 page end
  task automatic model_byte(input bit dc, input logic [7:0] b);
    if (dc) begin
      m_mem[m_page*128 + m_col]   = b;
      m_known[m_page*128 + m_col] = 1'b1;
      m_arg = 0;
      if (m_col == m_ce) begin
        m_col = m_cs;
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_frames++;
        end else m_page = (m_page + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end else begin
      case (m_arg)
        1: begin m_cs = b % 128; m_col = m_cs; m_arg = 2; end
        2: begin m_ce = b % 128; m_arg = 0; end
        3: begin m_ps = b % 8; m_page = m_ps; m_arg = 4; end
        4: begin m_pe = b % 8; m_arg = 0; end
        default: begin
          if (b == 8'h21) m_arg = 1;
          else if (b == 8'h22) m_arg = 3;
          else if (b == 8'hAF) m_disp = 1'b1;
          else if (b == 8'hAE) m_disp = 1'b0;
        end
      endcase
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input bit dc, input logic [7:0] v, input int n);
    ioDc = dc;
    for (int i = 7; i > 7 - n; i--) begin
      ioSdin = v[i];
      repeat (2) @(negedge clk);
      ioSclk = 1'b1;
      repeat (2) @(negedge clk);
      ioSclk = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    int v0;
    v0 = vcount;
    send_bits(dc, b, 8);
    repeat (8) @(negedge clk);
    model_byte(dc, b);
    check("valid_count", vcount - v0, 1);
    check("byte_data", int'(byteData), int'(b));
    check("byte_is_data", int'(byteIsData), int'(dc));
    check("display_on", int'(displayOn), int'(m_disp));
    check("frame_count", fcount, m_frames);
  endtask

  task automatic read_mem(input int a, output logic [7:0] d);
    pixelAddress = 10'(a);
    repeat (2) @(negedge clk);
    d = pixelData;
  endtask

  typedef struct {
    bit         dc;
    logic [7:0] b;
    bit         disp;
    int         frames;
    int         addr;   // -1: command, nothing written
  } vec_t;

  vec_t       tbl [17];
  logic [7:0] rd;
  int         f0, v0, pick;
  bit         rdc;
  logic [7:0] rb;
  logic [7:0] cmds [6];

  initial begin
    resetN = 1'b0; ioSclk = 1'b0; ioSdin = 1'b0; ioCs = 1'b1; ioDc = 1'b0;
    ioReset = 1'b1; pixelAddress = 10'd0;
    m_frames = 0;
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    model_reset();

    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 8'h5A, 1'b0, 0, 1};
    tbl[2]  = '{1'b0, 8'h21, 1'b0, 0, -1};
    tbl[3]  = '{1'b0, 8'h10, 1'b0, 0, -1};
    tbl[4]  = '{1'b0, 8'h11, 1'b0, 0, -1};
    tbl[5]  = '{1'b0, 8'h22, 1'b0, 0, -1};
    tbl[6]  = '{1'b0, 8'h02, 1'b0, 0, -1};
    tbl[7]  = '{1'b0, 8'h03, 1'b0, 0, -1};
    tbl[8]  = '{1'b1, 8'h01, 1'b0, 0, 272};
    tbl[9]  = '{1'b1, 8'h02, 1'b0, 0, 273};
    tbl[10] = '{1'b1, 8'h03, 1'b0, 0, 400};
    tbl[11] = '{1'b1, 8'h04, 1'b0, 1, 401};
    tbl[12] = '{1'b0, 8'hAF, 1'b1, 1, -1};
    tbl[13] = '{1'b0, 8'h8D, 1'b1, 1, -1};
    tbl[14] = '{1'b0, 8'hAE, 1'b0, 1, -1};
    tbl[15] = '{1'b0, 8'h8D, 1'b0, 1, -1};
    tbl[16] = '{1'b1, 8'h55, 1'b0, 1, 272};

    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_byte_valid", int'(byteValid), 0);
    check("rst_byte_data", int'(byteData), 0);
    check("rst_byte_is_data", int'(byteIsData), 0);
    check("rst_display_on", int'(displayOn), 0);
    check("rst_frame_done", int'(frameDone), 0);

    ioCs = 1'b0;
    repeat (2) @(negedge clk);
    f0 = fcount;
    foreach (tbl[i]) begin
      send_byte(tbl[i].dc, tbl[i].b);
      check("tbl_display_on", int'(displayOn), int'(tbl[i].disp));
      check("tbl_frames", fcount - f0, tbl[i].frames);
      if (tbl[i].addr >= 0) begin
        read_mem(tbl[i].addr, rd);
        check("tbl_mem", int'(rd), int'(tbl[i].b));
      end
    end
    read_mem(0, rd);
    check("mem_0_kept", int'(rd), 8'hA5);

    // Partial byte aborted by CS, then a clean byte.
    v0 = vcount;
    send_bits(1'b1, 8'hFF, 5);
    repeat (2) @(negedge clk);
    ioCs = 1'b1;
    repeat (6) @(negedge clk);
    ioCs = 1'b0;
    repeat (4) @(negedge clk);
    check("partial_no_pulse", vcount - v0, 0);
    send_byte(1'b1, 8'h3C);
    check("partial_one_pulse", vcount - v0, 1);
    read_mem(273, rd);
    check("partial_mem", int'(rd), 8'h3C);

    // Column window, then panel reset mid-stream.
    send_byte(1'b0, 8'h21);
    send_byte(1'b0, 8'h40);
    send_byte(1'b0, 8'h45);
    send_byte(1'b1, 8'h77);
    read_mem(448, rd);
    check("window_mem", int'(rd), 8'h77);
    send_byte(1'b0, 8'hAF);
    ioReset = 1'b0;
    repeat (6) @(negedge clk);
    ioReset = 1'b1;
    repeat (6) @(negedge clk);
    model_reset();
    check("ioreset_display_on", int'(displayOn), 0);
    check("ioreset_byte_data", int'(byteData), 0);
    send_byte(1'b1, 8'h99);
    send_byte(1'b1, 8'h98);
    read_mem(0, rd);
    check("ioreset_mem_0", int'(rd), 8'h99);
    read_mem(1, rd);
    check("ioreset_mem_1", int'(rd), 8'h98);
    read_mem(448, rd);
    check("ioreset_kept_448", int'(rd), 8'h77);
    read_mem(272, rd);
    check("ioreset_kept_272", int'(rd), 8'h55);

    // Full-frame stream with the default window: wrap on byte 1024 only.
    f0 = fcount;
    for (int i = 2; i < 1024; i++) begin
      send_byte(1'b1, 8'($urandom));
      if (i == 1022) check("no_frame_before_1024", fcount - f0, 0);
    end
    check("frame_on_1024", fcount - f0, 1);
    read_mem(1023, rd);
    check("mem_1023", int'(rd), int'(m_mem[1023]));
    send_byte(1'b1, 8'hC3);
    read_mem(0, rd);
    check("wrap_to_0", int'(rd), 8'hC3);

    // Random mix of commands and data against the model.
    cmds[0] = 8'h21; cmds[1] = 8'h22; cmds[2] = 8'hAF;
    cmds[3] = 8'hAE; cmds[4] = 8'h8D; cmds[5] = 8'h00;
    for (int i = 0; i < 250; i++) begin
      rdc = ($urandom_range(0, 99) < 55);
      pick = $urandom_range(0, 9);
      if (rdc || pick > 5) rb = 8'($urandom);
      else rb = cmds[pick];
      send_byte(rdc, rb);
    end
    for (int a = 0; a < 1024; a++) begin
      if (m_known[a]) begin
        read_mem(a, rd);
        check("rand_mem", int'(rd), int'(m_mem[a]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
